// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule
//  Description : DES round-key generator slaved to the external round counter;
//                issues K(r) (or K(17-r) when decrypting) on the edge cnt -> r.
//  Revision    : 1.0  initial release
// ============================================================================
module des_key_schedule #(
    parameter int CNT_W  = 5,
    parameter int ROUNDS = 16   // only 16 (DES) is meaningful
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      key_in,
    input  logic             decrypt,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cnt_end,
    output logic [47:0]      subkey,
    output logic             subkey_valid,
    output logic [3:0]       round_idx,
    output logic             subkey_last
);

    // Table entries are 1-based DES bit numbers; entry 1 sits in the top slot.
    localparam logic [56*6-1:0] c_pc1 = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [48*6-1:0] c_pc2 = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [27:0] rot28(input logic [27:0] x,
                                          input logic [1:0]  amt,
                                          input logic        right);
        logic [27:0] y;
        case ({right, amt})
            3'b0_01: y = {x[26:0], x[27]};
            3'b0_10: y = {x[25:0], x[27:26]};
            3'b1_01: y = {x[0],    x[27:1]};
            3'b1_10: y = {x[1:0],  x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    logic [27:0]      r_c;
    logic [27:0]      r_d;
    logic             r_mode;
    logic [47:0]      r_subkey;
    logic             r_valid;
    logic [3:0]       r_round_idx;
    logic             r_last;

    logic [55:0]      w_pc1;
    logic [47:0]      w_pc2;
    logic [27:0]      w_cs;
    logic [27:0]      w_ds;
    logic [27:0]      w_c_new;
    logic [27:0]      w_d_new;
    logic             w_mode;
    logic             w_first;
    logic             w_step;
    logic [CNT_W-1:0] w_r;
    logic [CNT_W-1:0] w_n;
    logic [1:0]       w_amt;
    logic             w_unused_parity;

    generate
        for (genvar i = 1; i <= 56; i++) begin : g_pc1
            localparam int c_src = int'(c_pc1[(56-i)*6 +: 6]);
            assign w_pc1[56-i] = key_in[64-c_src];
        end
        for (genvar i = 1; i <= 48; i++) begin : g_pc2
            localparam int c_src = int'(c_pc2[(48-i)*6 +: 6]);
            assign w_pc2[48-i] = (c_src <= 28) ? w_c_new[28-c_src] : w_d_new[56-c_src];
        end
    endgenerate

    assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign w_step  = start & ~cnt_end & (cnt < CNT_W'(ROUNDS));
    assign w_first = (cnt == '0);
    assign w_cs    = w_first ? w_pc1[55:28] : r_c;
    assign w_ds    = w_first ? w_pc1[27:0]  : r_d;
    assign w_mode  = w_first ? decrypt      : r_mode;

    // Decrypt walks the schedule backwards: undo the shift that produced the
    // next-higher round key, so round n uses s(18-r).
    always_comb begin
        w_r   = cnt + CNT_W'(1);
        w_n   = w_mode ? (CNT_W'(18) - w_r) : w_r;
        w_amt = 2'd2;
        if (w_n == CNT_W'(1) || w_n == CNT_W'(2) || w_n == CNT_W'(9) || w_n == CNT_W'(16))
            w_amt = 2'd1;
        if (w_mode && w_r == CNT_W'(1))
            w_amt = 2'd0;
    end

    assign w_c_new = rot28(w_cs, w_amt, w_mode);
    assign w_d_new = rot28(w_ds, w_amt, w_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c         <= '0;
            r_d         <= '0;
            r_mode      <= 1'b0;
            r_subkey    <= '0;
            r_valid     <= 1'b0;
            r_round_idx <= '0;
            r_last      <= 1'b0;
        end else if (!start) begin
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_round_idx <= '0;
        end else if (w_step) begin
            r_c         <= w_c_new;
            r_d         <= w_d_new;
            if (w_first)
                r_mode  <= decrypt;
            r_subkey    <= w_pc2;
            r_valid     <= 1'b1;
            r_round_idx <= 4'(cnt);
            r_last      <= (cnt == CNT_W'(ROUNDS - 1));
        end else begin
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end
    end

    assign subkey       = r_subkey;
    assign subkey_valid = r_valid;
    assign round_idx    = r_round_idx;
    assign subkey_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_key_schedule
//  Description : Scoreboard bench for des_key_schedule with an embedded round
//                counter and a bit-level software DES key-schedule model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,
                                  31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                                  29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                  26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                  51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic [4:0]  cnt;
    logic        cnt_end;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        subkey_last;

    des_key_schedule #(.CNT_W(5), .ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .decrypt(decrypt),
        .cnt(cnt), .cnt_end(cnt_end), .subkey(subkey), .subkey_valid(subkey_valid),
        .round_idx(round_idx), .subkey_last(subkey_last)
    );

    typedef struct packed {
        logic [47:0] k;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    int          vectors = 0;
    int          errors  = 0;
    int          pulses  = 0;
    logic [47:0] cap      [16];
    logic        cap_last [16];
    logic [63:0] run_key;
    logic        run_dec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Software key schedule: cumulative rotation of the PC-1 halves, then PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        bit          kb [1:64];
        bit          c0 [28];
        bit          d0 [28];
        bit          cd [1:56];
        int          t;
        logic [47:0] o;
        for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1_T[i]];
            d0[i] = kb[PC1_T[28+i]];
        end
        t = 0;
        for (int n = 1; n <= r; n++) t += SHIFTS[n-1];
        for (int i = 0; i < 28; i++) begin
            cd[i+1]  = c0[(i+t)%28];
            cd[29+i] = d0[(i+t)%28];
        end
        for (int i = 1; i <= 48; i++) o[48-i] = cd[PC2_T[i-1]];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Environment round counter; predicts each subkey the DUT must issue.
    assign cnt_end = (cnt == 5'd16);
    always @(posedge clk) begin
        int   r;
        exp_t e;
        if (!start) begin
            cnt <= 5'd0;
        end else if (!cnt_end && cnt < 5'd16) begin
            if (!rst) begin
                r = int'(cnt) + 1;
                if (cnt == 5'd0) begin
                    run_key = key_in;
                    run_dec = decrypt;
                end
                e.k    = ref_subkey(run_key, run_dec ? 17 - r : r);
                e.idx  = 4'(r - 1);
                e.last = (r == 16);
                exp_q.push_back(e);
            end
            cnt <= cnt + 5'd1;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (subkey_valid) begin
            pulses++;
            cap[round_idx]      = subkey;
            cap_last[round_idx] = subkey_last;
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_valid: got subkey %h idx %0d, expected none", subkey, round_idx);
            end else begin
                e = exp_q.pop_front();
                check("subkey", 64'(subkey), 64'(e.k));
                check("round_idx", 64'(round_idx), 64'(e.idx));
                check("subkey_last", 64'(subkey_last), 64'(e.last));
                check("cnt_align", 64'(cnt), 64'(round_idx) + 64'd1);
            end
        end else begin
            check("last_when_idle", 64'(subkey_last), 64'd0);
        end
    end

    task automatic run(input logic [63:0] k, input logic dec, input int ncyc);
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
        repeat (ncyc - 1) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          p;
        logic [63:0] kb;
        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        decrypt = 1'b0;
        #1;
        check("reset_subkey", 64'(subkey), 64'd0);
        check("reset_valid", 64'(subkey_valid), 64'd0);
        check("reset_idx", 64'(round_idx), 64'd0);
        check("reset_last", 64'(subkey_last), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        p = pulses;
        run(KNOWN_KEY, 1'b0, 18);
        check("enc_pulses", 64'(pulses - p), 64'd16);
        check("enc_K1", 64'(cap[0]), 64'h1B02EFFC7072);
        check("enc_K2", 64'(cap[1]), 64'h79AED9DBC9E5);
        check("enc_K16", 64'(cap[15]), 64'hCB3D8B0E17F5);
        check("enc_last16", 64'(cap_last[15]), 64'd1);

        run(KNOWN_KEY, 1'b1, 18);
        check("dec_cnt1", 64'(cap[0]), 64'hCB3D8B0E17F5);
        check("dec_cnt15", 64'(cap[14]), 64'h79AED9DBC9E5);
        check("dec_cnt16", 64'(cap[15]), 64'h1B02EFFC7072);

        // Hold start past round 16: output must freeze with valid low.
        p       = pulses;
        kb      = {$urandom, $urandom};
        key_in  = kb;
        decrypt = 1'b0;
        start   = 1'b1;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(subkey_valid), 64'd0);
            check("hold_last", 64'(subkey_last), 64'd0);
            check("hold_subkey", 64'(subkey), 64'(ref_subkey(kb, 16)));
        end
        check("hold_pulses", 64'(pulses - p), 64'd16);
        start = 1'b0;
        @(negedge clk);

        // Abort at cnt==7, restart with a new key.
        p       = pulses;
        key_in  = {$urandom, $urandom};
        decrypt = 1'b0;
        start   = 1'b1;
        repeat (7) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        kb = {$urandom, $urandom};
        run(kb, 1'b0, 18);
        check("abort_pulses", 64'(pulses - p), 64'd23);
        check("abort_newK1", 64'(cap[0]), 64'(ref_subkey(kb, 1)));

        // Asynchronous reset between edges mid-run.
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
        start   = 1'b1;
        repeat (5) @(negedge clk);
        p = pulses;
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("arst_subkey", 64'(subkey), 64'd0);
        check("arst_valid", 64'(subkey_valid), 64'd0);
        check("arst_idx", 64'(round_idx), 64'd0);
        check("arst_last", 64'(subkey_last), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("arst_no_issue", 64'(pulses - p), 64'd0);

        for (int n = 0; n < 200; n++)
            run({$urandom, $urandom}, 1'($urandom), 17 + int'($urandom_range(0, 2)));

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
